popcount_sequencer: RTL and testbench



---
 rtl/popcount_sequencer_pkg.sv | 23 ++
 rtl/popcount_sequencer_if.sv | 27 ++
 rtl/popcount_sequencer_slice_popcount.sv | 20 ++
 rtl/popcount_sequencer.sv | 108 ++++++++++
 tb/tb_popcount_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_sequencer_pkg.sv
// Shared types and constants for the sliced popcount sequencer: FSM encoding,
// default word/slice widths and the constant clog2 used to size counters.
package popcount_sequencer_pkg;

  localparam int DEF_WORD_W  = 32;
  localparam int DEF_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_sequencer_if.sv
// Producer/consumer handshake bundle for popcount_sequencer; the master side is
// the word producer plus result consumer, the slave side is the sequencer.
interface popcount_sequencer_if #(
  parameter int WORD_W = popcount_sequencer_pkg::DEF_WORD_W
) ();

  localparam int CNT_W = popcount_sequencer_pkg::clog2(WORD_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, busy
  );

endinterface

// File: rtl/popcount_sequencer_slice_popcount.sv
// Purely combinational ones counter for one SLICE_W-bit slice; zero latency,
// no handshake (the sequencer owns all flow control).
module slice_popcount
  import popcount_sequencer_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  localparam int PC_W   = clog2(SLICE_W + 1)
) (
  input  logic [SLICE_W-1:0] slice_i,
  output logic [PC_W-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      count_o = count_o + PC_W'(slice_i[i]);
    end
  end

endmodule

// File: rtl/popcount_sequencer.sv
// Counts ones in a WORD_W word one SLICE_W slice per cycle; result after NUM_SLICES cycles
// (1..NUM_SLICES with POPCOUNT_ZERO_SKIP_EN), held in DONE until out_ready, in_ready low while counting.
module popcount_sequencer
  import popcount_sequencer_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic               clk,
  input  logic               rst,
  popcount_sequencer_if.slave bus
);

  localparam int NUM_SLICES = WORD_W / SLICE_W;
  localparam int CNT_W      = clog2(WORD_W + 1);
  localparam int PC_W       = clog2(SLICE_W + 1);
  localparam int IDX_W      = (NUM_SLICES > 1) ? clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [PC_W-1:0]   slice_cnt;
  logic              accept;
  logic              last_slice;

  slice_popcount #(
    .SLICE_W (SLICE_W)
  ) u_slice_popcount (
    .slice_i (shreg_q[SLICE_W-1:0]),
    .count_o (slice_cnt)
  );

`ifdef POPCOUNT_ZERO_SKIP_EN
  // Once nothing but zeros remains above the current slice, this slice is the last.
  assign last_slice = (idx_q == LAST_IDX) || ((shreg_q >> SLICE_W) == '0);
`else
  assign last_slice = (idx_q == LAST_IDX);
`endif

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_count = acc_q;
  assign bus.busy      = (state_q == COUNT);
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_q + CNT_W'(slice_cnt);
        shreg_d = shreg_q >> SLICE_W;
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // accept implies out_ready here, so a new word can follow with no idle cycle
        if (accept) begin
          shreg_d = bus.in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_count)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(acc_q) <= WORD_W));

endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: directed words with literal expectations plus a
// cycle-level behavioural model that checks every output on every cycle.
module tb_popcount_sequencer;
  import popcount_sequencer_pkg::*;

  localparam int WORD_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NS      = WORD_W / SLICE_W;
`ifdef POPCOUNT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_sequencer_if #(.WORD_W(WORD_W)) bus ();

  popcount_sequencer #(
    .WORD_W  (WORD_W),
    .SLICE_W (SLICE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Cycles from acceptance to result: fixed, or set by the highest nonzero slice.
  function automatic int ref_lat(input logic [31:0] d);
    int hi;
    hi = 1;
    for (int s = 0; s < NS; s++) begin
      if (d[s*SLICE_W +: SLICE_W] != '0) hi = s + 1;
    end
    return ZS ? hi : NS;
  endfunction

  // Behavioural model: at most one word in flight, result due ref_lat edges after acceptance.
  bit m_flight = 1'b0;
  int m_age    = 0;
  int m_lat    = 0;
  int m_cnt    = 0;
  int n_acc    = 0;
  int n_done   = 0;

  always @(negedge clk) begin
    bit ev, er, eb;
    if (rst) begin
      m_flight = 1'b0;
      m_age    = 0;
    end else begin
      ev = m_flight && (m_age >= m_lat);
      er = !m_flight || (ev && bus.out_ready);
      eb = m_flight && !ev;
      chk("m_out_valid", int'(bus.out_valid), int'(ev));
      chk("m_in_ready", int'(bus.in_ready), int'(er));
      chk("m_busy", int'(bus.busy), int'(eb));
      if (ev) chk("m_out_count", int'(bus.out_count), m_cnt);
      if (ev && bus.out_ready) begin
        m_flight = 1'b0;
        n_done   = n_done + 1;
      end else if (m_flight) begin
        m_age = m_age + 1;
      end
      if (er && bus.in_valid) begin
        m_flight = 1'b1;
        m_age    = 0;
        m_cnt    = $countones(bus.in_data);
        m_lat    = ref_lat(bus.in_data);
        n_acc    = n_acc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("accept_timeout", w, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_word(input string name, input logic [31:0] d,
                          input int exp_cnt, input int exp_lat);
    int n;
    send(d);
    wait_valid(n);
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_cnt"}, int'(bus.out_count), exp_cnt);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_released"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    #2000000;
    errors = errors + 1;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    int base_acc, base_done;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);

    run_word("all_ones", 32'hFFFF_FFFF, 32, 4);
    run_word("ends",     32'h8000_0001, 2,  4);
    run_word("zero",     32'h0000_0000, 0,  ZS ? 1 : 4);
    run_word("lsb",      32'h0000_0001, 1,  ZS ? 1 : 4);
    run_word("mid",      32'h0001_0000, 1,  ZS ? 3 : 4);

    // Backpressure: result held for five cycles with out_ready low
    send(32'h0F0F_0F0F);
    wait_valid(n);
    chk("bp_lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", int'(bus.out_valid), 1);
      chk("bp_hold_count", int'(bus.out_count), 16);
      chk("bp_hold_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_released_valid", int'(bus.out_valid), 0);
    chk("bp_released_in_ready", int'(bus.in_ready), 1);
    tick();
    chk("bp_single_handshake", int'(bus.out_valid), 0);

    // Back-to-back: new word accepted in the DONE cycle
    send(32'h8000_0001);
    wait_valid(n);
    chk("b2b_first_cnt", int'(bus.out_count), 2);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_00FF;
    #1;
    chk("b2b_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    chk("b2b_no_idle", int'(bus.busy), 1);
    wait_valid(n);
    chk("b2b_lat", n, ZS ? 1 : 4);
    chk("b2b_cnt", int'(bus.out_count), 8);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset two cycles into a count
    send(32'hFFFF_FFFF);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_out_count", int'(bus.out_count), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_spurious_valid", int'(bus.out_valid), 0);
    end
    run_word("after_rst", 32'h0000_0003, 2, ZS ? 1 : 4);

    // Random traffic with throttling on both sides; the model checks every cycle
    base_acc  = n_acc;
    base_done = n_done;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] d;
          bit got;
          int w;
          repeat ($urandom_range(0, 2)) tick();
          case ($urandom_range(0, 3))
            0:       d = $urandom;
            1:       d = $urandom >> $urandom_range(0, 31);
            2:       d = $urandom & $urandom & $urandom;
            default: d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
          endcase
          bus.in_valid = 1'b1;
          bus.in_data  = d;
          got = 1'b0;
          w = 0;
          while (!got && w < 100) begin
            @(negedge clk);
            got = bus.in_ready;
            tick();
            w++;
          end
          if (!got) chk("rand_accept_timeout", w, 0);
          bus.in_valid = 1'b0;
          bus.in_data  = '0;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while ((n_done - base_done) < 1000 && cyc < 40000) begin
          tick();
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        bus.out_ready = 1'b0;
      end
    join
    chk("rand_words_accepted", n_acc - base_acc, 1000);
    chk("rand_results_taken", n_done - base_done, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
